// File: rtl/ext_reg_pkg.sv
// Shared definitions for the ext_out_reg responder: address map, FSM states
// and the address-class decoder.
package ext_reg_pkg;

    localparam logic [5:0] ADDR_REG_BASE = 6'h00;
    localparam logic [5:0] ADDR_STB      = 6'h20;
    localparam logic [5:0] ADDR_INTCLR   = 6'h21;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_COMMIT
    } state_t;

    typedef enum logic [1:0] {
        AC_REG,
        AC_STB,
        AC_INTCLR,
        AC_BAD
    } addr_class_t;

    // Everything below the STB address is register file; 0x22 and up is unmapped.
    function automatic addr_class_t decode_addr(input logic [5:0] addr);
        addr_class_t c;
        if (addr < ADDR_STB) begin
            c = AC_REG;
        end else if (addr == ADDR_STB) begin
            c = AC_STB;
        end else if (addr == ADDR_INTCLR) begin
            c = AC_INTCLR;
        end else begin
            c = AC_BAD;
        end
        return c;
    endfunction

endpackage

// File: rtl/ext_reg_file.sv
// Configuration register file: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old value.
module ext_reg_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32,
    localparam int unsigned AW        = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage write plus read-first registered read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ext_reg_responder.sv
// Responder end of the ext_out_reg write bus. Each accepted write is held for
// WAIT_CYCLES cycles (modelling parameter-RAM latency) and then committed as a
// register write, a one-cycle strobe vector or an interrupt-clear mask.
module ext_reg_responder
    import ext_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned CNT_WIDTH   = 16,
    localparam int unsigned AW         = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ext_out_reg_stb,
    input  logic [5:0]            ext_out_reg_addr,
    input  logic [DATA_WIDTH-1:0] ext_out_reg_data,
    output logic                  ext_out_reg_busy,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_stbs,
    input  logic [DATA_WIDTH-1:0] set_ints,
    output logic [DATA_WIDTH-1:0] pending_ints,
    output logic [CNT_WIDTH-1:0]  write_count,
    output logic                  bad_addr,
    output logic                  overrun
);

    localparam int unsigned WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    state_t                r_state;
    logic [3:0]            r_wait_cnt;
    logic [5:0]            r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_stbs;
    logic [DATA_WIDTH-1:0] r_pend;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_bad;
    logic                  r_ovr;

    addr_class_t           w_class;
    logic                  w_commit;
    logic                  w_reg_we;
    logic [AW-1:0]         w_reg_idx;
    logic [DATA_WIDTH-1:0] w_clr_mask;

    assign w_class    = decode_addr(r_addr);
    assign w_commit   = (r_state == S_COMMIT);
    assign w_reg_we   = w_commit && (w_class == AC_REG);
    assign w_reg_idx  = AW'(r_addr - ADDR_REG_BASE);
    assign w_clr_mask = (w_commit && (w_class == AC_INTCLR)) ? r_data : '0;

    ext_reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regs (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_reg_we),
        .i_wr_addr (w_reg_idx),
        .i_wr_data (r_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    // Accept/wait/commit sequencing with all side-effect outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_stbs     <= '0;
            r_pend     <= '0;
            r_count    <= '0;
            r_bad      <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_stbs <= '0;
            // Set is OR-ed after the clear so a same-cycle set wins.
            r_pend <= (r_pend & ~w_clr_mask) | set_ints;
            if (ext_out_reg_stb && r_busy) begin
                r_ovr <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (ext_out_reg_stb) begin
                        r_addr <= ext_out_reg_addr;
                        r_data <= ext_out_reg_data;
                        r_busy <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            r_wait_cnt <= 4'(WAIT_LOAD);
                            r_state    <= S_WAIT;
                        end else begin
                            r_state <= S_COMMIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_COMMIT: begin
                    if (w_class == AC_STB) begin
                        r_stbs <= r_data;
                    end
                    if (w_class == AC_BAD) begin
                        r_bad <= 1'b1;
                    end
                    r_count <= r_count + 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ext_out_reg_busy = r_busy;
    assign out_stbs         = r_stbs;
    assign pending_ints     = r_pend;
    assign write_count      = r_count;
    assign bad_addr         = r_bad;
    assign overrun          = r_ovr;

endmodule

// File: tb/tb_ext_reg_responder.sv
// Bench for ext_reg_responder: directed writes, expected commit results are
// queued at issue time and checked by a monitor when busy falls.
module tb_ext_reg_responder;

    logic        clk;
    logic        rst;
    logic        stb;
    logic [5:0]  addr;
    logic [31:0] data;
    logic        busy;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] out_stbs;
    logic [31:0] set_ints;
    logic [31:0] pending_ints;
    logic [15:0] write_count;
    logic        bad_addr;
    logic        overrun;

    // Second instance: zero wait and a narrow counter so wrap is reachable.
    logic        stb2;
    logic        busy2;
    logic [31:0] rd_data2;
    logic [31:0] out_stbs2;
    logic [31:0] pending2;
    logic [3:0]  count2;
    logic        bad2;
    logic        ovr2;

    typedef struct {
        logic [15:0] cnt;
        logic [31:0] stbs;
        logic [31:0] pend;
        logic        bad;
        logic        ovr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_busy = 1'b0;

    ext_reg_responder #(
        .DATA_WIDTH  (32),
        .NUM_REGS    (32),
        .WAIT_CYCLES (2),
        .CNT_WIDTH   (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ext_out_reg_stb  (stb),
        .ext_out_reg_addr (addr),
        .ext_out_reg_data (data),
        .ext_out_reg_busy (busy),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .out_stbs         (out_stbs),
        .set_ints         (set_ints),
        .pending_ints     (pending_ints),
        .write_count      (write_count),
        .bad_addr         (bad_addr),
        .overrun          (overrun)
    );

    ext_reg_responder #(
        .DATA_WIDTH  (32),
        .NUM_REGS    (32),
        .WAIT_CYCLES (0),
        .CNT_WIDTH   (4)
    ) dut2 (
        .clk              (clk),
        .rst              (rst),
        .ext_out_reg_stb  (stb2),
        .ext_out_reg_addr (6'h01),
        .ext_out_reg_data (32'h0000_00AA),
        .ext_out_reg_busy (busy2),
        .rd_addr          (5'd1),
        .rd_data          (rd_data2),
        .out_stbs         (out_stbs2),
        .set_ints         (32'h0),
        .pending_ints     (pending2),
        .write_count      (count2),
        .bad_addr         (bad2),
        .overrun          (ovr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] c, input logic [31:0] s, input logic [31:0] p,
                        input logic b, input logic o);
        exp_t e;
        e.cnt = c; e.stbs = s; e.pend = p; e.bad = b; e.ovr = o;
        sb.push_back(e);
    endtask

    // Drive stb for one cycle (cycle 0); returns in cycle 1.
    task automatic issue(input logic [5:0] a, input logic [31:0] d);
        stb = 1'b1; addr = a; data = d;
        tick();
        stb = 1'b0;
    endtask

    // From cycle 1: check busy through cycle 4, optionally driving set_ints in cycle 3.
    task automatic finish_txn(input logic [31:0] setv);
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("busy_c%0d", c), {31'b0, busy}, 32'd1);
            if (c == 3) set_ints = setv;
            tick();
        end
        set_ints = '0;
        chk("busy_c4", {31'b0, busy}, 32'd0);
    endtask

    // Scoreboard monitor: each busy fall is one commit.
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: commit seen with no expected entry at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("mon_count", {16'b0, write_count}, {16'b0, e.cnt});
                    chk("mon_stbs", out_stbs, e.stbs);
                    chk("mon_pend", pending_ints, e.pend);
                    chk("mon_bad", {31'b0, bad_addr}, {31'b0, e.bad});
                    chk("mon_ovr", {31'b0, overrun}, {31'b0, e.ovr});
                end
            end else begin
                chk("stbs_quiet", out_stbs, 32'h0);
            end
            prev_busy = busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stb = 1'b0; addr = '0; data = '0; rd_addr = '0; set_ints = '0; stb2 = 1'b0;
        tick(); tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rd", rd_data, 32'h0);
        chk("rst_stbs", out_stbs, 32'h0);
        chk("rst_pend", pending_ints, 32'h0);
        chk("rst_count", {16'b0, write_count}, 32'h0);
        chk("rst_flags", {30'b0, bad_addr, overrun}, 32'h0);
        chk("rst_count2", {28'b0, count2}, 32'h0);
        #2 rst = 1'b0;
        tick();

        // Register write, then read-first / latency check on the same address.
        rd_addr = 5'd5;
        push(16'd1, 32'h0, 32'h0, 1'b0, 1'b0);
        issue(6'h05, 32'hDEAD_BEEF);
        finish_txn(32'h0);
        chk("rd_old_c4", rd_data, 32'h0);
        // Back-to-back STB write in the first idle cycle; its cycle 1 is cycle 5 above.
        push(16'd2, 32'h0000_0005, 32'h0, 1'b0, 1'b0);
        issue(6'h20, 32'h0000_0005);
        chk("rd_new_c5", rd_data, 32'hDEAD_BEEF);
        finish_txn(32'h0);
        tick();

        // Interrupt set then clear of bits 1:0.
        set_ints = 32'h0000_000F;
        tick();
        set_ints = '0;
        chk("pend_set", pending_ints, 32'h0000_000F);
        push(16'd3, 32'h0, 32'h0000_000C, 1'b0, 1'b0);
        issue(6'h21, 32'h0000_0003);
        finish_txn(32'h0);
        // Same clear with bit 1 being set in the commit cycle: set wins.
        push(16'd4, 32'h0, 32'h0000_000E, 1'b0, 1'b0);
        issue(6'h21, 32'h0000_0003);
        finish_txn(32'h0000_0002);
        tick();

        // Overrun: second stb in cycle 2 is dropped.
        push(16'd5, 32'h0, 32'h0000_000E, 1'b0, 1'b1);
        issue(6'h07, 32'h1111_1111);
        tick();
        stb = 1'b1; addr = 6'h08; data = 32'h2222_2222;
        tick();
        stb = 1'b0;
        chk("ovr_c3", {31'b0, overrun}, 32'd1);
        chk("busy_ovr_c3", {31'b0, busy}, 32'd1);
        tick();
        chk("busy_ovr_c4", {31'b0, busy}, 32'd0);

        // Unmapped address, issued back-to-back.
        push(16'd6, 32'h0, 32'h0000_000E, 1'b1, 1'b1);
        issue(6'h3A, 32'hFFFF_FFFF);
        finish_txn(32'h0);
        rd_addr = 5'h1A; tick();
        chk("rd_unmapped_alias", rd_data, 32'h0);
        rd_addr = 5'd7; tick();
        chk("rd_reg7", rd_data, 32'h1111_1111);
        rd_addr = 5'd8; tick();
        chk("rd_reg8_dropped", rd_data, 32'h0);
        rd_addr = 5'd5; tick();
        chk("rd_reg5_kept", rd_data, 32'hDEAD_BEEF);

        // Reset in WAIT aborts the write.
        rd_addr = 5'd3;
        issue(6'h03, 32'h1234_5678);
        tick();
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_count", {16'b0, write_count}, 32'h0);
        chk("abort_flags", {30'b0, bad_addr, overrun}, 32'h0);
        chk("abort_pend", pending_ints, 32'h0);
        tick();
        #2 rst = 1'b0;
        tick(); tick();
        chk("abort_reg3", rd_data, 32'h0);
        push(16'd1, 32'h0, 32'h0, 1'b0, 1'b0);
        issue(6'h03, 32'hA5A5_A5A5);
        finish_txn(32'h0);
        tick();
        chk("post_rst_reg3", rd_data, 32'hA5A5_A5A5);

        // Zero-wait instance: 16 writes wrap the 4-bit counter to 0.
        for (int i = 0; i < 16; i++) begin
            stb2 = 1'b1;
            tick();
            stb2 = 1'b0;
            if (i == 0) chk("w0_busy_c1", {31'b0, busy2}, 32'd1);
            tick();
            if (i == 0) chk("w0_busy_c2", {31'b0, busy2}, 32'd0);
            chk($sformatf("wrap_count_%0d", i), {28'b0, count2}, 32'((i + 1) % 16));
        end

        tick(); tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
